lcd_init_seq: RTL
=================

# lcd_init_seq

Sequencer that owns the LCD byte bus from power-on until the panel is initialised, then hands it to the pixel/command client. It pulses the panel reset line, then walks an internal ROM of command, data and delay entries. Each byte goes to the SPI byte transmitter through a valid/ready handshake. It sits in `chip` between the POR-qualified reset and the LCD byte transmitter that drives `sda`/`scl`/`cs`/`rs`, and muxes the frame-writer stream onto the same transmitter once `init_done` rises.

## Interface
- `DELAY_UNIT`, 25000: clock cycles per ROM delay unit (1 ms at 25 MHz).
- `RST_LOW_CYCLES`, 250: `lcd_rst` low time (10 µs).
- `RST_WAIT_CYCLES`, 3000000: wait after reset release before the first ROM entry (120 ms).
- `ROM_DEPTH`, 16: number of ROM entries; address width is clog2(`ROM_DEPTH`).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; restarts the whole sequence.
- `restart` in 1: single-cycle request to rerun the sequence; honoured only in DONE.
- `lcd_rst` out 1: panel reset, active-low.
- `tx_valid` out 1: byte available to the transmitter.
- `tx_ready` in 1: transmitter accepts the byte on a cycle where `tx_valid && tx_ready`.
- `tx_data` out 8: byte to send.
- `tx_dc` out 1: 0 = command, 1 = data; drives `rs`.
- `client_valid` in 1, `client_data` in 8, `client_dc` in 1: frame-writer stream.
- `client_ready` out 1: frame-writer accept.
- `init_done` out 1: high while the bus belongs to the client.

## Operation
- ROM entry is 10 bits, `{op[1:0], payload[7:0]}`:
  - op 00: send command byte (dc=0).
  - op 01: send data byte (dc=1).
  - op 10: delay `payload`×`DELAY_UNIT` cycles.
  - op 11: end of sequence.
- Fixed contents, in order:
  - 01 (SWRESET), delay 150, 11 (SLPOUT), delay 255.
  - 3A, data 05 (COLMOD 16 bpp).
  - 36, data C8 (MADCTL).
  - 29 (DISPON), delay 10, end.
  - Unused entries are end.
- States:
  - RST_LOW: `lcd_rst`=0 for `RST_LOW_CYCLES`.
  - RST_WAIT: `lcd_rst`=1 for `RST_WAIT_CYCLES`.
  - FETCH: 1 cycle, synchronous ROM read at current address.
  - SEND: `tx_valid`=1 with `tx_data`/`tx_dc` stable until the handshake, then address+1 → FETCH.
  - DELAY: count, then address+1 → FETCH.
  - DONE: bus handed to the client.
- End handling:
  - An op 11 entry goes to DONE.
  - The address reaching `ROM_DEPTH` is also treated as end; the address never wraps.
- Delay payload 0 lasts zero DELAY cycles: FETCH goes directly to the next FETCH.
- Delay is implemented as nested unit/count counters with no multiplier. The maximum span is 255×`DELAY_UNIT`.
- DONE is a combinational pass-through:
  - `tx_valid`=`client_valid`, `tx_data`=`client_data`, `tx_dc`=`client_dc`.
  - `client_ready`=`tx_ready`.
- Outside DONE, `client_ready`=0 and client inputs are ignored.
- `restart` in DONE:
  - Moves to RST_LOW (or FETCH at address 0 when reset pulse is compiled out) on the next edge.
  - `init_done` drops on the same edge.
  - A client byte handshaking in that same cycle is still accepted.
  - `restart` in any other state is ignored.

## Timing
- Reset values:
  - State RST_LOW, or FETCH when the reset pulse is compiled out; address 0.
  - `lcd_rst`=0 (1 without macro), `tx_valid`=0, `tx_data`=0, `tx_dc`=0.
  - `client_ready`=0, `init_done`=0.
- `reset` mid-transfer: `tx_valid` drops the next cycle and the byte is abandoned. The transmitter must tolerate this.
- Send entry cost:
  - 1 FETCH cycle + SEND cycles until handshake, inclusive.
  - With `tx_ready` held high, each byte costs exactly 2 cycles.
- Delay entry N: 1 FETCH + N×`DELAY_UNIT` DELAY cycles.
- `init_done` rises on the edge that enters DONE. Client traffic may flow in that same cycle.
- `tx_valid` never deasserts in SEND before the handshake, and `tx_data`/`tx_dc` never change while `tx_valid && !tx_ready`.

## Configuration
- `LCD_RESET_PULSE_EN` defined:
  - RST_LOW and RST_WAIT exist and `lcd_rst` is driven as described.
  - `restart` re-pulses the panel.
- Not defined:
  - `lcd_rst` is tied to 1 and both reset states are removed.
  - Reset and `restart` enter FETCH at address 0 directly.
  - The panel relies on SWRESET only.

## Test plan
Bench parameters: `DELAY_UNIT`=4, `RST_LOW_CYCLES`=3, `RST_WAIT_CYCLES`=5, `tx_ready`=1 unless stated.
- Reset release with macro → `lcd_rst` low exactly 3 cycles, high 5 cycles, then first `tx_valid` with `tx_data`=01, `tx_dc`=0.
- Full run → byte/dc log is 01/0, 11/0, 3A/0, 05/1, 36/0, C8/1, 29/0. Gap between 01 accept and 11 valid is 1+600 cycles. `init_done` rises 1+40 cycles after the 29 handshake.
- `tx_ready` held low 7 cycles during the 3A byte → `tx_valid` and data stable for all 7 cycles; 05 follows only after the 3A handshake.
- In DONE, client sends AA/1 with `tx_ready` toggling → `tx_*` mirrors client and `client_ready` equals `tx_ready` each cycle. `restart` pulse → `init_done` 0 next cycle and the sequence replays.
- `reset` asserted mid-SEND of 36 → next cycle `tx_valid`=0, `init_done`=0, `lcd_rst`=0; full sequence replays from 01.
- Macro undefined → `lcd_rst` constantly 1; first `tx_valid` (01) on the second cycle after reset release.

Source files
------------

// File: rtl/lcd_init_seq.sv
// LCD power-on sequencer: optional panel reset pulse (LCD_RESET_PULSE_EN), ROM of command/data/delay entries, then client pass-through.
// Each ROM byte costs 1 FETCH cycle plus SEND cycles until the handshake; tx_* holds steady under backpressure; client_ready = tx_ready only in DONE.
module lcd_init_seq #(
   parameter int DELAY_UNIT      = 25000,
   parameter int RST_LOW_CYCLES  = 250,
   parameter int RST_WAIT_CYCLES = 3000000,
   parameter int ROM_DEPTH       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   output logic       lcd_rst,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_dc,
   input  logic       client_valid,
   input  logic [7:0] client_data,
   input  logic       client_dc,
   output logic       client_ready,
   output logic       init_done
);
   localparam int AW   = $clog2(ROM_DEPTH);
   localparam int TMAX0 = (RST_WAIT_CYCLES > RST_LOW_CYCLES) ? RST_WAIT_CYCLES : RST_LOW_CYCLES;
   localparam int TMAX = (TMAX0 > DELAY_UNIT) ? TMAX0 : DELAY_UNIT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] UNIT_LAST = TW'(DELAY_UNIT - 1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(ROM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_RST_LOW, S_RST_WAIT, S_FETCH, S_SEND, S_DELAY, S_DONE
   } state_t;

`ifdef LCD_RESET_PULSE_EN
   localparam logic [TW-1:0] LOW_LAST  = TW'(RST_LOW_CYCLES - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(RST_WAIT_CYCLES - 1);
   localparam state_t START = S_RST_LOW;
`else
   localparam state_t START = S_FETCH;
`endif

   // Entry layout {op[1:0], payload[7:0]}: 00 cmd, 01 data, 10 delay, 11 end.
   function automatic logic [9:0] rom_entry(input logic [AW-1:0] a);
      logic [9:0] e;
      case (a)
         AW'(0):  e = {2'b00, 8'h01};
         AW'(1):  e = {2'b10, 8'd150};
         AW'(2):  e = {2'b00, 8'h11};
         AW'(3):  e = {2'b10, 8'd255};
         AW'(4):  e = {2'b00, 8'h3A};
         AW'(5):  e = {2'b01, 8'h05};
         AW'(6):  e = {2'b00, 8'h36};
         AW'(7):  e = {2'b01, 8'hC8};
         AW'(8):  e = {2'b00, 8'h29};
         AW'(9):  e = {2'b10, 8'd10};
         default: e = {2'b11, 8'h00};
      endcase
      return e;
   endfunction

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      data_q, data_d;
   logic            dc_q, dc_d;
   logic [9:0]      entry;
   logic            advance;
   logic            in_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= START;
         addr_q  <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dc_q    <= dc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dc_d    = dc_q;
      advance = 1'b0;
      entry   = rom_entry(addr_q);
      case (state_q)
`ifdef LCD_RESET_PULSE_EN
         S_RST_LOW: begin
            if (tmr_q == LOW_LAST) begin
               state_d = S_RST_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (tmr_q == WAIT_LAST) begin
               state_d = S_FETCH;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
`endif
         S_FETCH: begin
            case (entry[9:8])
               2'b00, 2'b01: begin
                  state_d = S_SEND;
                  data_d  = entry[7:0];
                  dc_d    = entry[8];
               end
               2'b10: begin
                  if (entry[7:0] == 8'd0) begin
                     advance = 1'b1;
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = entry[7:0];
                     tmr_d   = '0;
                  end
               end
               default: state_d = S_DONE;
            endcase
         end
         S_SEND: advance = tx_ready;
         // Inner counter spans one delay unit, outer counts units down to 1.
         S_DELAY: begin
            if (tmr_q == UNIT_LAST) begin
               tmr_d = '0;
               if (cnt_q == 8'd1) advance = 1'b1;
               else               cnt_d   = cnt_q - 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_DONE: begin
            if (restart) begin
               state_d = START;
               addr_d  = '0;
               tmr_d   = '0;
            end
         end
         default: state_d = START;
      endcase
      // Running off the last ROM slot ends the sequence instead of wrapping.
      if (advance) begin
         if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
         end else begin
            state_d = S_FETCH;
            addr_d  = addr_q + 1'b1;
         end
      end
   end

   assign in_done = (state_q == S_DONE);

`ifdef LCD_RESET_PULSE_EN
   assign lcd_rst = (state_q != S_RST_LOW);
`else
   assign lcd_rst = 1'b1;
`endif

   assign tx_valid     = in_done ? client_valid : (state_q == S_SEND);
   assign tx_data      = in_done ? client_data  : data_q;
   assign tx_dc        = in_done ? client_dc    : dc_q;
   assign client_ready = in_done & tx_ready;
   assign init_done    = in_done;

endmodule
